pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Parametrised hazard, forwarding and flush controller for the 5-stage pipeline (IF, ID, EX, MEM, WB).
- Keeps its own shadow pipeline of destination, source and control info for EX, MEM and WB.
- Produces EX operand forward selects, load-use stalls, multi-cycle data-memory freezes and branch flushes.
- Replaces the separate combinational hazard-detection and forwarding units. Adds a configurable branch-resolution stage and a memory wait handshake.

Parameters:
- REG_AW, 5: register address width.
- BR_STAGE, 2: stage where branches resolve. 1 = EX, 2 = MEM.
- PERF_W, 32: width of the performance counters (optional feature only).

Ports:
- CLK input 1: clock, rising edge.
- RST input 1: reset, asynchronous, active-low.
- id_valid input 1: the ID stage holds a real instruction.
- id_rs1, id_rs2 input REG_AW: ID source registers.
- id_use_rs1, id_use_rs2 input 1: the ID instruction actually reads rs1 / rs2.
- id_rd input REG_AW: ID destination register.
- id_reg_write input 1: the ID instruction writes the register file.
- id_mem_read input 1: the ID instruction is a load.
- id_mem_access input 1: the ID instruction is a load or a store.
- br_taken input 1: branch taken, resolved in stage BR_STAGE.
- dmem_ready input 1: data memory has completed the access of the instruction in MEM.
- pc_write output 1: PC load enable.
- ifid_write output 1: IF/ID register enable.
- ifid_flush output 1: clear IF/ID.
- idex_bubble output 1: load a NOP into ID/EX.
- idex_flush output 1: clear ID/EX.
- exmem_flush output 1: clear EX/MEM.
- pipe_freeze output 1: hold ID/EX, EX/MEM and MEM/WB.
- fwd_a, fwd_b output 2: EX operand selects. 00 = register file, 10 = EX/MEM result, 01 = MEM/WB result.

Behaviour:
- Shadow stages: EX, MEM and WB, each holding valid, rd, rs1, rs2, use bits, reg_write, mem_read and mem_access.
- Normal advance each cycle: ID inputs go to EX, EX to MEM, MEM to WB.
- All outputs are combinational from the shadow state and the current inputs. Shadow registers update on the rising edge of CLK.
- Reset (RST=0), asynchronous:
  - every shadow valid = 0;
  - pc_write = 1 and ifid_write = 1;
  - all flush, bubble and freeze outputs = 0;
  - fwd_a = fwd_b = 00.
- Forwarding, evaluated for the EX shadow stage:
  - fwd_a = 10 if MEM.valid, MEM.reg_write, MEM.rd != 0 and MEM.rd == EX.rs1.
  - Otherwise fwd_a = 01 if the same conditions hold against WB.
  - Otherwise fwd_a = 00.
  - fwd_b uses rs2 with the same rules.
  - EX/MEM has priority over MEM/WB.
  - A source register of x0 never forwards.
- Load-use stall (1 cycle):
  - Condition: EX.valid, EX.mem_read, EX.rd != 0, and (id_use_rs1 with id_rs1 == EX.rd, or id_use_rs2 with id_rs2 == EX.rd).
  - Response: pc_write = 0, ifid_write = 0, idex_bubble = 1.
  - The EX shadow takes valid = 0 on the next edge. MEM and WB advance.
- Memory freeze:
  - Condition: MEM.valid, MEM.mem_access and dmem_ready = 0.
  - Response: pipe_freeze = 1, pc_write = 0, ifid_write = 0. All shadow stages hold.
  - Lasts an unbounded number of cycles. Released in the cycle dmem_ready = 1.
- Branch flush, taken only when not frozen and br_taken = 1:
  - Always: ifid_flush = 1 and idex_flush = 1.
  - BR_STAGE = 2 additionally asserts exmem_flush = 1.
  - pc_write stays 1 so the PC loads the target.
  - Flushed shadow stages take valid = 0.
- Priority, highest first: freeze > branch flush > load-use stall.
  - During a freeze, br_taken is ignored. It is re-sampled once the freeze ends.
  - A load-use condition in the same cycle as a taken branch produces no stall, because the ID instruction is flushed.
- Forward selects are computed even during a freeze. They stay stable because the shadow stages hold.
- Reset asserted mid-stall or mid-freeze aborts immediately. No pending state survives.

Optional Feature:
- Macro HAZ_PERF_CNT_EN. When defined, adds these ports:
  - perf_clr input 1: synchronous clear of all counters.
  - perf_lu_stall output PERF_W: load-use stall cycles.
  - perf_mem_wait output PERF_W: freeze cycles.
  - perf_flush output PERF_W: taken-branch flush events.
- Counters reset to 0 and saturate at all-ones. perf_clr has priority over an increment in the same cycle.
- When undefined, the ports and logic are absent. Core behaviour is identical.

Test Plan:
- Back-to-back ALU ops: add x5 in EX→MEM, next instruction reads x5 as rs1 → fwd_a=10. One cycle later, an instruction in EX reading x5 as rs2 → fwd_b=01.
- Writes to x0 in MEM and WB with EX rs1=rs2=0 → fwd_a=fwd_b=00.
- Load x7 in EX with id_rs2=7 and id_use_rs2=1:
  - exactly 1 cycle of pc_write=0, ifid_write=0, idex_bubble=1;
  - the following cycle, the consumer in EX gets fwd_b=01.
- Load in MEM with dmem_ready low for 3 cycles → pipe_freeze=1 for 3 cycles and fwd selects held. Freeze drops in the cycle dmem_ready=1.
- BR_STAGE=2, br_taken=1 → ifid_flush, idex_flush and exmem_flush all 1 for 1 cycle. A coincident load-use condition gives idex_bubble=0.
- br_taken=1 during a freeze → no flush until the freeze ends. RST low mid-freeze → pc_write=1 and pipe_freeze=0 immediately. With HAZ_PERF_CNT_EN, perf_mem_wait=2 after a 2-cycle freeze.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and flush controller for a 5-stage pipeline, tracking EX/MEM/WB in shadow stages.
// Optional performance counters are enabled with the HAZ_PERF_CNT_EN macro.
module pipe_hazard_ctrl #(
  parameter int REG_AW   = 5,
  parameter int BR_STAGE = 2,
  parameter int PERF_W   = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_access,
  input  logic              br_taken,
  input  logic              dmem_ready,
`ifdef HAZ_PERF_CNT_EN
  input  logic              perf_clr,
  output logic [PERF_W-1:0] perf_lu_stall,
  output logic [PERF_W-1:0] perf_mem_wait,
  output logic [PERF_W-1:0] perf_flush,
`endif
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic              idex_flush,
  output logic              exmem_flush,
  output logic              pipe_freeze,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
);

  localparam bit BR_IN_MEM = (BR_STAGE == 2);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              use_rs1;
    logic              use_rs2;
    logic              reg_write;
    logic              mem_read;
    logic              mem_access;
  } stage_t;

  stage_t ex_q, ex_d;
  stage_t mem_q, mem_d;
  stage_t wb_q, wb_d;
  stage_t id_stage;

  logic freeze;
  logic flush;
  logic load_use;
  logic [1:0] fwd_a_raw;
  logic [1:0] fwd_b_raw;

  always_comb begin
    id_stage.valid      = id_valid;
    id_stage.rd         = id_rd;
    id_stage.rs1        = id_rs1;
    id_stage.rs2        = id_rs2;
    id_stage.use_rs1    = id_use_rs1;
    id_stage.use_rs2    = id_use_rs2;
    id_stage.reg_write  = id_reg_write;
    id_stage.mem_read   = id_mem_read;
    id_stage.mem_access = id_mem_access;
  end

  // Priority: an outstanding data access freezes everything, then a taken branch, then load-use.
  always_comb begin
    freeze   = mem_q.valid && mem_q.mem_access && !dmem_ready;
    flush    = !freeze && br_taken;
    load_use = !freeze && !flush && ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) &&
               ((id_use_rs1 && (id_rs1 == ex_q.rd)) || (id_use_rs2 && (id_rs2 == ex_q.rd)));
  end

  always_comb begin
    fwd_a_raw = 2'b00;
    if ((ex_q.rs1 != '0) && mem_q.valid && mem_q.reg_write && (mem_q.rd == ex_q.rs1)) begin
      fwd_a_raw = 2'b10;
    end else if ((ex_q.rs1 != '0) && wb_q.valid && wb_q.reg_write && (wb_q.rd == ex_q.rs1)) begin
      fwd_a_raw = 2'b01;
    end
    fwd_b_raw = 2'b00;
    if ((ex_q.rs2 != '0) && mem_q.valid && mem_q.reg_write && (mem_q.rd == ex_q.rs2)) begin
      fwd_b_raw = 2'b10;
    end else if ((ex_q.rs2 != '0) && wb_q.valid && wb_q.reg_write && (wb_q.rd == ex_q.rs2)) begin
      fwd_b_raw = 2'b01;
    end
  end

  // Outputs are gated by RST so a taken branch seen during reset cannot flush.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    pipe_freeze = 1'b0;
    fwd_a       = 2'b00;
    fwd_b       = 2'b00;
    if (RST) begin
      pc_write    = !(freeze || load_use);
      ifid_write  = !(freeze || load_use);
      ifid_flush  = flush;
      idex_bubble = load_use;
      idex_flush  = flush;
      exmem_flush = flush && BR_IN_MEM;
      pipe_freeze = freeze;
      fwd_a       = fwd_a_raw;
      fwd_b       = fwd_b_raw;
    end
  end

  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (!freeze) begin
      wb_d  = mem_q;
      mem_d = ex_q;
      ex_d  = id_stage;
      if (flush || load_use) begin
        ex_d.valid = 1'b0;
      end
      if (flush && BR_IN_MEM) begin
        mem_d.valid = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  // Shadow fields kept for completeness but not consumed by the hazard rules.
  logic shadow_unused;
  assign shadow_unused = ^{ex_q.use_rs1, ex_q.use_rs2, ex_q.reg_write, ex_q.mem_access,
                           mem_q.rs1, mem_q.rs2, mem_q.use_rs1, mem_q.use_rs2, mem_q.mem_read,
                           wb_q.rs1, wb_q.rs2, wb_q.use_rs1, wb_q.use_rs2, wb_q.mem_read,
                           wb_q.mem_access};

`ifdef HAZ_PERF_CNT_EN
  logic [PERF_W-1:0] lu_cnt_q, lu_cnt_d;
  logic [PERF_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [PERF_W-1:0] flush_cnt_q, flush_cnt_d;

  // Saturating counters; a clear wins over an increment in the same cycle.
  always_comb begin
    lu_cnt_d    = lu_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (perf_clr) begin
      lu_cnt_d    = '0;
      wait_cnt_d  = '0;
      flush_cnt_d = '0;
    end else begin
      if (load_use && (lu_cnt_q != '1)) begin
        lu_cnt_d = lu_cnt_q + 1'b1;
      end
      if (freeze && (wait_cnt_q != '1)) begin
        wait_cnt_d = wait_cnt_q + 1'b1;
      end
      if (flush && (flush_cnt_q != '1)) begin
        flush_cnt_d = flush_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      lu_cnt_q    <= '0;
      wait_cnt_q  <= '0;
      flush_cnt_q <= '0;
    end else begin
      lu_cnt_q    <= lu_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_lu_stall = lu_cnt_q;
  assign perf_mem_wait = wait_cnt_q;
  assign perf_flush    = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a queue-based instruction model predicts every cycle's outputs.
// Perf counter checks are active when HAZ_PERF_CNT_EN is defined.
module tb_pipe_hazard_ctrl;

  localparam int REG_AW   = 5;
  localparam int BR_STAGE = 2;
  localparam int PERF_W   = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              id_mem_access;
  logic              br_taken;
  logic              dmem_ready;
  logic              perf_clr_r;
  logic              pc_write;
  logic              ifid_write;
  logic              ifid_flush;
  logic              idex_bubble;
  logic              idex_flush;
  logic              exmem_flush;
  logic              pipe_freeze;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
`ifdef HAZ_PERF_CNT_EN
  logic [PERF_W-1:0] perf_lu_stall;
  logic [PERF_W-1:0] perf_mem_wait;
  logic [PERF_W-1:0] perf_flush;
`endif

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_AW(REG_AW), .BR_STAGE(BR_STAGE), .PERF_W(PERF_W)) dut (
    .CLK          (clk),
    .RST          (rst_n),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .id_mem_access(id_mem_access),
    .br_taken     (br_taken),
    .dmem_ready   (dmem_ready),
`ifdef HAZ_PERF_CNT_EN
    .perf_clr     (perf_clr_r),
    .perf_lu_stall(perf_lu_stall),
    .perf_mem_wait(perf_mem_wait),
    .perf_flush   (perf_flush),
`endif
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .ifid_flush   (ifid_flush),
    .idex_bubble  (idex_bubble),
    .idex_flush   (idex_flush),
    .exmem_flush  (exmem_flush),
    .pipe_freeze  (pipe_freeze),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b)
  );

  logic [10:0] dut_out;
  assign dut_out = {pc_write, ifid_write, ifid_flush, idex_bubble, idex_flush,
                    exmem_flush, pipe_freeze, fwd_a, fwd_b};

  typedef struct {
    bit v;
    int rd;
    int rs1;
    int rs2;
    bit u1;
    bit u2;
    bit rw;
    bit mr;
    bit ma;
  } ins_t;

  // Model pipeline: index 0 = EX, 1 = MEM, 2 = WB.
  ins_t        pipe[$];
  logic [10:0] sb[$];
  string       sb_name[$];
  int          checks   = 0;
  int          failures = 0;
  logic [PERF_W-1:0] m_lu;
  logic [PERF_W-1:0] m_wait;
  logic [PERF_W-1:0] m_flush;

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic clearModel();
    ins_t e;
    e = '{default: 0};
    pipe.delete();
    repeat (3) pipe.push_back(e);
    m_lu    = '0;
    m_wait  = '0;
    m_flush = '0;
  endtask

  function automatic int fwdOf(int src);
    if (src != 0 && pipe[1].v && pipe[1].rw && pipe[1].rd == src) return 2;
    if (src != 0 && pipe[2].v && pipe[2].rw && pipe[2].rd == src) return 1;
    return 0;
  endfunction

  function automatic logic [PERF_W-1:0] satInc(logic [PERF_W-1:0] c);
    return (c == {PERF_W{1'b1}}) ? c : c + 1'b1;
  endfunction

  // Drives one cycle of ID/branch/memory inputs, queues the predicted outputs, advances the model.
  task automatic applyStimulus(input bit v, input int rd, input int rs1, input int rs2,
                               input bit u1, input bit u2, input bit rw, input bit mr,
                               input bit ma, input bit br, input bit rdy, input string tag);
    ins_t        id;
    logic [10:0] exp;
    bit          frz, fl, lu;
    id_valid      = v;
    id_rd         = REG_AW'(rd);
    id_rs1        = REG_AW'(rs1);
    id_rs2        = REG_AW'(rs2);
    id_use_rs1    = u1;
    id_use_rs2    = u2;
    id_reg_write  = rw;
    id_mem_read   = mr;
    id_mem_access = ma;
    br_taken      = br;
    dmem_ready    = rdy;
    id = '{v: v, rd: rd, rs1: rs1, rs2: rs2, u1: u1, u2: u2, rw: rw, mr: mr, ma: ma};
    if (!rst_n) begin
      exp = {1'b1, 1'b1, 9'b0};
      clearModel();
    end else begin
      frz = pipe[1].v && pipe[1].ma && !rdy;
      fl  = !frz && br;
      lu  = !frz && !fl && pipe[0].v && pipe[0].mr && pipe[0].rd != 0 &&
            ((u1 && rs1 == pipe[0].rd) || (u2 && rs2 == pipe[0].rd));
      exp = {!(frz || lu), !(frz || lu), fl, lu, fl, fl && (BR_STAGE == 2), frz,
             2'(fwdOf(pipe[0].rs1)), 2'(fwdOf(pipe[0].rs2))};
      if (perf_clr_r) begin
        m_lu = '0; m_wait = '0; m_flush = '0;
      end else begin
        if (lu)  m_lu    = satInc(m_lu);
        if (frz) m_wait  = satInc(m_wait);
        if (fl)  m_flush = satInc(m_flush);
      end
      if (!frz) begin
        void'(pipe.pop_back());
        if (fl && BR_STAGE == 2) pipe[0].v = 1'b0;
        if (fl || lu) id.v = 1'b0;
        pipe.push_front(id);
      end
    end
    sb.push_back(exp);
    sb_name.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic alu(input int rd, input int rs1, input int rs2, input string tag);
    applyStimulus(1, rd, rs1, rs2, 1, 1, 1, 0, 0, 0, 1, tag);
  endtask

  task automatic ld(input int rd, input int rs1, input string tag);
    applyStimulus(1, rd, rs1, 0, 1, 0, 1, 1, 1, 0, 1, tag);
  endtask

  task automatic nop(input string tag);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, tag);
  endtask

  // Monitor: outputs are sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    logic [10:0] exp;
    string       nm;
    if (sb.size() > 0) begin
      exp = sb.pop_front();
      nm  = sb_name.pop_front();
      checkOutput(nm, {21'b0, dut_out}, {21'b0, exp});
    end
  end

  initial begin
    rst_n      = 1'b0;
    perf_clr_r = 1'b0;
    clearModel();
    @(posedge clk);
    #1;
    applyStimulus(1, 3, 3, 3, 1, 1, 1, 1, 1, 1, 0, "reset-state");
    applyStimulus(1, 2, 2, 2, 1, 1, 1, 0, 0, 1, 1, "reset-state");
    rst_n = 1'b1;

    alu(5, 1, 2, "alu-prod");
    alu(6, 5, 3, "alu-c1");
    alu(8, 4, 5, "fwd-exmem");
    nop("fwd-memwb");
    nop("alu-drain");
    nop("alu-drain");

    alu(0, 1, 2, "x0-w1");
    alu(0, 1, 2, "x0-w2");
    alu(9, 0, 0, "x0-read");
    nop("x0-no-fwd");
    nop("x0-drain");
    nop("x0-drain");

    ld(7, 1, "lu-load");
    alu(10, 1, 7, "lu-stall");
    alu(10, 1, 7, "lu-reissue");
    nop("lu-fwd-b");
    nop("lu-drain");
    nop("lu-drain");

    ld(3, 2, "frz-load");
    alu(12, 3, 3, "frz-next");
    repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "freeze");
    nop("freeze-release");
    nop("frz-drain");
    nop("frz-drain");

    ld(4, 1, "br-load");
    applyStimulus(1, 11, 4, 4, 1, 1, 1, 0, 0, 1, 1, "br-vs-lu");
    nop("br-drain");
    nop("br-drain");
    nop("br-drain");

    ld(3, 2, "fb-load");
    nop("fb-next");
    repeat (2) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, "freeze-br");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, "br-after-freeze");
    nop("fb-drain");
    nop("fb-drain");

    for (int i = 0; i < 3000; i++) begin
      bit mr, ma;
      mr = ($urandom_range(0, 3) == 0);
      ma = mr || ($urandom_range(0, 5) == 0);
      applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1),
                    mr || ($urandom_range(0, 1) == 1), mr, ma,
                    $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0, "random");
    end

    perf_clr_r = 1'b1;
    nop("perf-clear");
    perf_clr_r = 1'b0;
    ld(3, 2, "perf-load");
    nop("perf-next");
    repeat (2) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "perf-freeze");
    nop("perf-release");
`ifdef HAZ_PERF_CNT_EN
    checkOutput("perf_mem_wait", perf_mem_wait, m_wait);
    checkOutput("perf_mem_wait_two", perf_mem_wait, 32'd2);
    checkOutput("perf_lu_stall", perf_lu_stall, m_lu);
    checkOutput("perf_flush", perf_flush, m_flush);
`endif

    ld(3, 2, "rf-load");
    nop("rf-next");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, "rf-freeze");
    id_valid   = 1'b0;
    dmem_ready = 1'b0;
    br_taken   = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst-mid-freeze pc_write", {31'b0, pc_write}, 32'd1);
    checkOutput("rst-mid-freeze pipe_freeze", {31'b0, pipe_freeze}, 32'd0);
    checkOutput("rst-mid-freeze ifid_flush", {31'b0, ifid_flush}, 32'd0);
    clearModel();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    nop("post-rst");
    ld(7, 1, "post-rst-load");
    alu(10, 1, 7, "post-rst-stall");
    nop("post-rst-drain");
    nop("post-rst-drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
